// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage IEEE 754 add/sub, RNE rounding,
// subnormals, NaN/inf/zero handling and exception flags.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] res,
  output logic                 flag_nv,
  output logic                 flag_of,
  output logic                 flag_uf,
  output logic                 flag_nx
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;
  localparam int EW1 = EXP_W + 1;
  localparam int LW  = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LW-1:0] f_lzc(
    input logic [SW-1:0] v
  );
    f_lzc = LW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) f_lzc = LW'(SW - 1 - i);
  endfunction

  logic w_adv;
  logic r_ov;

  assign w_adv    = ~(r_ov & ~out_ready);
  assign in_ready = w_adv;

  logic             w_sa, w_sb, w_sx, w_sy, w_swap;
  logic [EXP_W-1:0] w_ea, w_eb, w_exr, w_eyr;
  logic [EXP_W-1:0] w_ex, w_ey, w_diff;
  logic [MAN_W-1:0] w_fa, w_fb, w_fx, w_fy;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic             w_snan, w_spec, w_nv;
  logic [W-1:0]     w_sres;
  logic [SW-1:0]    w_mx, w_my0, w_my;
  logic [2*SW-1:0]  w_wide;

  assign w_sa = a[W-1];
  assign w_ea = a[W-2:MAN_W];
  assign w_fa = a[MAN_W-1:0];
  assign w_sb = b[W-1] ^ op_sub;
  assign w_eb = b[W-2:MAN_W];
  assign w_fb = b[MAN_W-1:0];

  assign w_a_nan = (w_ea == EMAX) && (w_fa != '0);
  assign w_b_nan = (w_eb == EMAX) && (w_fb != '0);
  assign w_a_inf = (w_ea == EMAX) && (w_fa == '0);
  assign w_b_inf = (w_eb == EMAX) && (w_fb == '0);
  assign w_snan  = (w_a_nan & ~w_fa[MAN_W-1]) |
                   (w_b_nan & ~w_fb[MAN_W-1]);

  always_comb begin
    w_spec = 1'b1;
    w_nv   = 1'b0;
    w_sres = QNAN;
    if (w_a_nan || w_b_nan)
      w_nv = w_snan;
    else if (w_a_inf && w_b_inf && (w_sa != w_sb))
      w_nv = 1'b1;
    else if (w_a_inf)
      w_sres = {w_sa, EMAX, {MAN_W{1'b0}}};
    else if (w_b_inf)
      w_sres = {w_sb, EMAX, {MAN_W{1'b0}}};
    else
      w_spec = 1'b0;
  end

  assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};
  assign w_sx   = w_swap ? w_sb : w_sa;
  assign w_sy   = w_swap ? w_sa : w_sb;
  assign w_exr  = w_swap ? w_eb : w_ea;
  assign w_eyr  = w_swap ? w_ea : w_eb;
  assign w_fx   = w_swap ? w_fb : w_fa;
  assign w_fy   = w_swap ? w_fa : w_fb;
  assign w_ex   = (w_exr == '0) ? EXP_W'(1) : w_exr;
  assign w_ey   = (w_eyr == '0) ? EXP_W'(1) : w_eyr;
  assign w_mx   = {w_exr != '0, w_fx, 3'b000};
  assign w_my0  = {w_eyr != '0, w_fy, 3'b000};
  assign w_diff = w_ex - w_ey;
  assign w_wide = {w_my0, {SW{1'b0}}} >> w_diff;

  // bits shifted past S fold into the sticky bit
  always_comb begin
    w_my    = w_wide[2*SW-1:SW];
    w_my[0] = w_wide[SW] | (|w_wide[SW-1:0]);
    if (32'(w_diff) >= MAN_W + 3) begin
      w_my    = '0;
      w_my[0] = |w_my0;
    end
  end

  logic             r1_v, r1_spec, r1_nv, r1_sx, r1_sy;
  logic [W-1:0]     r1_sres;
  logic [EXP_W-1:0] r1_ex;
  logic [SW-1:0]    r1_mx, r1_my;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_v    <= 1'b0;
      r1_spec <= 1'b0;
      r1_nv   <= 1'b0;
      r1_sx   <= 1'b0;
      r1_sy   <= 1'b0;
      r1_sres <= '0;
      r1_ex   <= '0;
      r1_mx   <= '0;
      r1_my   <= '0;
    end else if (w_adv) begin
      r1_v    <= in_valid;
      r1_spec <= w_spec;
      r1_nv   <= w_nv;
      r1_sx   <= w_sx;
      r1_sy   <= w_sy;
      r1_sres <= w_sres;
      r1_ex   <= w_ex;
      r1_mx   <= w_mx;
      r1_my   <= w_my;
    end
  end

  logic [SW:0]    w_sum;
  logic [LW-1:0]  w_lz;
  int             w_sh;
  logic [SW-1:0]  w_nm;
  logic [EW1-1:0] w_ne;
  logic           w_ns;

  assign w_sum = (r1_sx ^ r1_sy) ?
                 {1'b0, r1_mx} - {1'b0, r1_my} :
                 {1'b0, r1_mx} + {1'b0, r1_my};
  assign w_lz  = f_lzc(w_sum[SW-1:0]);
  assign w_ns  = (w_sum == '0) ? (r1_sx & r1_sy) : r1_sx;

  // left shift stops at exponent 1, leaving a subnormal
  always_comb begin
    w_sh = int'(w_lz);
    if (w_sh > int'(r1_ex) - 1)
      w_sh = int'(r1_ex) - 1;
    w_nm = w_sum[SW-1:0] << w_sh;
    w_ne = EW1'(int'(r1_ex) - w_sh);
    if (w_sum[SW]) begin
      w_nm    = w_sum[SW:1];
      w_nm[0] = w_sum[1] | w_sum[0];
      w_ne    = {1'b0, r1_ex} + EW1'(1);
    end
  end

  logic           r2_v, r2_spec, r2_nv, r2_s;
  logic [W-1:0]   r2_sres;
  logic [EW1-1:0] r2_e;
  logic [SW-1:0]  r2_m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r2_v    <= 1'b0;
      r2_spec <= 1'b0;
      r2_nv   <= 1'b0;
      r2_s    <= 1'b0;
      r2_sres <= '0;
      r2_e    <= '0;
      r2_m    <= '0;
    end else if (w_adv) begin
      r2_v    <= r1_v;
      r2_spec <= r1_spec;
      r2_nv   <= r1_nv;
      r2_s    <= w_ns;
      r2_sres <= r1_sres;
      r2_e    <= w_ne;
      r2_m    <= w_nm;
    end
  end

  logic             w_g, w_r, w_s, w_inc, w_ovf;
  logic             w_hid, w_inx;
  logic [MAN_W+1:0] w_rm;
  logic [EW1-1:0]   w_e3;
  logic [W-1:0]     w_res;
  logic [3:0]       w_fl;

  assign w_g   = r2_m[2];
  assign w_r   = r2_m[1];
  assign w_s   = r2_m[0];
  assign w_inc = w_g & (w_r | w_s | r2_m[3]);
  assign w_inx = w_g | w_r | w_s;
  assign w_rm  = {1'b0, r2_m[SW-1:3]} +
                 {{(MAN_W+1){1'b0}}, w_inc};
  assign w_ovf = w_rm[MAN_W+1];
  assign w_hid = w_rm[MAN_W] | w_ovf;
  assign w_e3  = r2_e + {{EXP_W{1'b0}}, w_ovf};

  always_comb begin
    w_res = {r2_s,
             w_hid ? w_e3[EXP_W-1:0] : {EXP_W{1'b0}},
             w_rm[MAN_W-1:0]};
    w_fl  = {2'b00, ~w_hid & w_inx, w_inx};
    if (r2_spec) begin
      w_res = r2_sres;
      w_fl  = {r2_nv, 3'b000};
    end else if (w_e3 >= {1'b0, EMAX}) begin
      w_res = {r2_s, EMAX, {MAN_W{1'b0}}};
      w_fl  = 4'b0101;
    end
  end

  logic [W-1:0] r_res;
  logic [3:0]   r_fl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ov  <= 1'b0;
      r_res <= '0;
      r_fl  <= '0;
    end else if (w_adv) begin
      r_ov  <= r2_v;
      r_res <= w_res;
      r_fl  <= w_fl;
    end
  end

  assign out_valid = r_ov;
  assign res       = r_res;
  assign flag_nv   = r_fl[3];
  assign flag_of   = r_fl[2];
  assign flag_uf   = r_fl[1];
  assign flag_nx   = r_fl[0];
endmodule
